// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, FSM states and the
// opcode-to-hold-cycle mapping.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_MUL = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SHL = 4'd3;
    localparam logic [3:0] OP_SHR = 4'd4;
    localparam logic [3:0] OP_SAR = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;
    localparam logic [3:0] OP_DIV = 4'd10;
    localparam logic [3:0] OP_LAST = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [6:0] op_latency(
        input logic [3:0]  op,
        input int unsigned simple_c,
        input int unsigned mul_c,
        input int unsigned div_c
    );
        logic [6:0] lat;
        case (op)
            OP_MUL:  lat = 7'(mul_c);
            OP_DIV:  lat = 7'(div_c);
            default: lat = 7'(simple_c);
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-input round-robin arbiter; the requester not granted last wins a tie.
module alu_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant    = '0;
        grant[0] = req[0] & (~req[1] | last);
        grant[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/alu_scheduler.sv
// Arbitrates two requesters onto a shared ALU, holds operands for the
// opcode's settle time and returns the tagged result on one response channel.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned SIMPLE_CYCLES = 1,
    parameter int unsigned MUL_CYCLES    = 40,
    parameter int unsigned DIV_CYCLES    = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    input  logic        r1_valid,
    output logic        r0_ready,
    output logic        r1_ready,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [3:0]  r0_op,
    input  logic [3:0]  r1_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_s,
    output logic        resp_carry,
    output logic        resp_overflow,
    output logic        resp_zero,
    output logic        resp_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_s,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_zero
);

    state_t      state;
    state_t      state_next;
    logic        last;
    logic [5:0]  cnt;
    logic [1:0]  grant;
    logic        accept;
    logic        sel_id;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_legal;
    logic [6:0]  lat_m1;

    alu_rr_arb2 u_arb (
        .req   ({r1_valid, r0_valid}),
        .last  (last),
        .grant (grant)
    );

    always_comb begin
        sel_id    = grant[1];
        sel_op    = sel_id ? r1_op : r0_op;
        sel_a     = sel_id ? r1_a  : r0_a;
        sel_b     = sel_id ? r1_b  : r0_b;
        sel_legal = (sel_op <= OP_LAST) && !(sel_op == OP_DIV && sel_b == '0);
        lat_m1    = op_latency(sel_op, SIMPLE_CYCLES, MUL_CYCLES, DIV_CYCLES) - 7'd1;
    end

    // Ready is masked during reset so the first accept can only happen after release.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        r0_ready   = 1'b0;
        r1_ready   = 1'b0;
        resp_valid = (state == RESP);
        case (state)
            IDLE: begin
                if (!rst && (grant != 2'b00)) begin
                    accept     = 1'b1;
                    r0_ready   = grant[0];
                    r1_ready   = grant[1];
                    state_next = sel_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (cnt == '0) state_next = RESP;
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last          <= 1'b1;
            cnt           <= '0;
            resp_id       <= 1'b0;
            resp_s        <= '0;
            resp_carry    <= 1'b0;
            resp_overflow <= 1'b0;
            resp_zero     <= 1'b0;
            resp_err      <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_control   <= '0;
        end else if (accept) begin
            last    <= sel_id;
            resp_id <= sel_id;
            if (sel_legal) begin
                alu_a       <= sel_a;
                alu_b       <= sel_b;
                alu_control <= sel_op;
                cnt         <= lat_m1[5:0];
            end else begin
                resp_s        <= '0;
                resp_carry    <= 1'b0;
                resp_overflow <= 1'b0;
                resp_zero     <= 1'b0;
                resp_err      <= 1'b1;
            end
        end else if (state == EXEC) begin
            if (cnt == '0) begin
                resp_s        <= alu_s;
                resp_carry    <= alu_carry;
                resp_overflow <= alu_overflow;
                resp_zero     <= alu_zero;
                resp_err      <= 1'b0;
            end else begin
                cnt <= cnt - 6'd1;
            end
        end
    end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencer and two-way arbiter in front of the shared 32-bit ALU (`main`: A, B, control[3:0] → S, carry, overflow, zero). Accepts operation requests from two requesters over valid/ready channels and grants the ALU round-robin. Holds operands stable for an opcode-dependent number of cycles so multi-cycle multiply and divide settle. Returns the captured result and flags on a single response channel tagged with the requester id.

## Interface
- `SIMPLE_CYCLES`, default 1: hold cycles for opcodes 0 and 2–9.
- `MUL_CYCLES`, default 40: hold cycles for opcode 1 (multiply).
- `DIV_CYCLES`, default 40: hold cycles for opcode 10 (divide).
- Ports:
  - `clk` in 1: single clock. All state updates on the rising edge.
  - `rst` in 1: synchronous, active-high reset.
  - `r0_valid`, `r1_valid` in 1 each: request present.
  - `r0_ready`, `r1_ready` out 1 each: request accepted this edge when paired with valid.
  - `r0_a`, `r0_b`, `r1_a`, `r1_b` in 32 each: operands.
  - `r0_op`, `r1_op` in 4 each: ALU control code.
  - `resp_valid` out 1, `resp_ready` in 1: response handshake.
  - `resp_id` out 1: 0 = requester 0, 1 = requester 1.
  - `resp_s` out 32: result.
  - `resp_carry`, `resp_overflow`, `resp_zero`, `resp_err` out 1 each: flags and error.
  - `alu_a`, `alu_b` out 32, `alu_control` out 4: registered drive to the ALU.
  - `alu_s` in 32, `alu_carry`, `alu_overflow`, `alu_zero` in 1 each: ALU outputs.

## Operation
- Opcodes: 0 add, 1 mul, 2 sub, 3 shl, 4 shr, 5 sar, 6 and, 7 or, 8 not, 9 xor, 10 div. Codes 11–15 are illegal.
- States: IDLE, EXEC, RESP. Only one operation is outstanding at a time.
- Readiness:
  - `rX_ready` is high only in IDLE, and only for the granted requester.
  - Ready is combinational from state, the valids and the round-robin pointer.
- Arbitration:
  - If exactly one valid is high, that requester is granted.
  - If both are high, the requester not granted last is granted.
  - The `last` pointer resets to 1, so r0 wins the first contention.
  - `last` updates on every accept.
- Accept edge (IDLE, granted valid high), legal opcode and not (op==10 && b==0):
  - Load `alu_a`, `alu_b`, `alu_control` from the granted requester.
  - Load the counter with LAT−1, where LAT is the hold-cycle parameter for the opcode.
  - Latch the id and go to EXEC.
- Accept edge, illegal opcode or divide by zero:
  - ALU registers are left unchanged.
  - Go straight to RESP with `resp_s`=0, all flags 0, `resp_err`=1.
- EXEC:
  - Counter decrements each cycle.
  - On the edge where the counter is 0: capture `alu_s`/`alu_carry`/`alu_overflow`/`alu_zero` into the resp registers, set `resp_err`=0, go to RESP.
- RESP:
  - `resp_valid`=1; all resp outputs are held stable until `resp_valid && resp_ready`.
  - On that handshake edge, go to IDLE.
- ALU operand registers keep their last values after completion; they are not cleared.
- Counter is 6 bits. Parameters must be in 1..64; LAT=1 means capture on the first edge after accept.

## Timing
- Reset values:
  - All outputs are 0, including `resp_valid`, `rX_ready`, `alu_*`, `resp_*` and `resp_id`.
  - State is IDLE, counter 0, `last`=1.
- `rX_ready` can go high in the first cycle after reset release.
- Latency, with accept at edge E:
  - Legal op: `resp_valid` rises after edge E+LAT. Add is valid after E+1; mul after E+MUL_CYCLES.
  - Error op: `resp_valid` rises after edge E.
- Throughput: response handshake at edge H makes the next accept possible no earlier than edge H+1. That is one bubble, with no same-edge accept.
- `resp_ready` held low stalls indefinitely: both ready signals stay low and no request is lost.
- Request inputs are sampled only on the accept edge; later changes to them are ignored.
- `rst` asserted in any state (including mid-EXEC or RESP):
  - Next edge forces the reset values.
  - The in-flight result is discarded and no response is issued.

## Structure
- Package `alu_pkg`:
  - Opcode localparams (`OP_ADD`…`OP_DIV`) and `OP_LAST`=10.
  - State enum {IDLE, EXEC, RESP}.
  - Function `op_latency(op)` returning hold cycles from the three parameters passed in.
- Sub-module `alu_rr_arb2`: two-input round-robin arbiter.
  - Inputs `req[1:0]`, `last`. Output one-hot `grant[1:0]`.
  - Purely combinational; the `last` register lives in the scheduler.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Simple add: r0 sends op 0, a=7, b=9. Then a=4294967295, b=2.
  - Results S=16 (zero=0), then S=1 with carry=1.
  - `resp_valid` exactly 1 cycle after each accept; `resp_id`=0.
- Multiply: r1 sends op 1, a=36544, b=262.
  - S=9574528.
  - `alu_*` stable for MUL_CYCLES cycles; `resp_valid` exactly MUL_CYCLES after accept.
- Contention: both valid from reset, r0 add 5+5, r1 sub 6843−4567.
  - r0 is served first (S=10), then r1 (S=2276, `resp_id`=1).
  - A second simultaneous pair is served r0 then r1 again (alternation).
- Errors:
  - op 10, a=0, b=0 gives `resp_err`=1, S=0, one cycle after accept, and `alu_control` unchanged.
  - op 13 gives the same.
  - op 10, a=503, b=10 gives S=50, err=0.
- Backpressure: `resp_ready` low for 20 cycles after an xor completes.
  - `resp_*` stable throughout, both ready signals low.
  - Response accepted on the `resp_ready` edge; next accept one cycle later.
- Reset mid-divide: `rst` asserted 10 cycles into a DIV_CYCLES=40 operation.
  - All outputs 0 the next cycle and no response ever appears.
  - After release, r0 wins the first contention.
